// File: rtl/phy_pkg.sv
// Shared PHY constants used by the receive lane combiner and the transmit striper.
//   ComDefault    : idle/comma symbol sent on idle lanes
//   ActCntDefault : consecutive idle COM symbols that bring a lane up
//   calc_bpw()    : symbols per word for a given word/symbol width
package phy_pkg;

  localparam logic [7:0] ComDefault = 8'hBC;
  localparam int unsigned ActCntDefault = 4;

  function automatic int unsigned calc_bpw(input int unsigned word_w, input int unsigned sym_w);
    return word_w / sym_w;
  endfunction

endpackage

// File: rtl/phy_lane_word_fifo.sv
// Per-lane word FIFO that absorbs inter-lane skew ahead of the round-robin unstriper.
// Ports:
//   i_clk, i_reset : byte clock, synchronous active-high reset (clears pointers and count)
//   i_push, i_wdata: write one word; dropped when full unless a pop happens in the same cycle
//   i_pop          : remove the head word (ignored when empty)
//   o_rdata        : head word, valid whenever o_empty is low
//   o_full/o_empty : occupancy flags
//   o_overflow     : single-cycle pulse when a pushed word is dropped
module phy_lane_word_fifo #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_push,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic              i_pop,
  output logic [WORD_W-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_overflow
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]   r_wptr;
  logic [PtrW-1:0]   r_rptr;
  logic [CntW-1:0]   r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == CntW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot, so a push on a full FIFO is then legal.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_overflow = i_push & o_full & ~w_do_pop;
  assign o_rdata   = r_mem[r_rptr];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= ptr_inc(r_wptr);
      if (w_do_pop)  r_rptr <= ptr_inc(r_rptr);
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/phy_rx_lane_deskew.sv
// Receive-side lane combiner: per-lane activity detect, byte-to-word assembly,
// per-lane deskew FIFOs and round-robin unstriping into a single word stream.
// Ports:
//   clk_4f        : byte clock (single clock domain)
//   reset         : synchronous active-high reset, discards all partial and stored data
//   lane_data_in  : lane i symbol at [i*SYM_W +: SYM_W]
//   lane_valid_in : lane i symbol is data when 1, idle when 0
//   data_out      : unstriped word, holds its value while valid_out is low
//   valid_out     : data_out carries a new word this cycle
//   active        : per-lane activity flag, sticky until reset
//   skew_err      : sticky flag, set the cycle after any FIFO drops a word
module phy_rx_lane_deskew
  import phy_pkg::*;
#(
  parameter int unsigned      LANES      = 2,
  parameter int unsigned      SYM_W      = 8,
  parameter int unsigned      WORD_W     = 32,
  parameter int unsigned      SKEW_DEPTH = 4,
  parameter logic [SYM_W-1:0] COM        = SYM_W'(ComDefault),
  parameter int unsigned      ACT_CNT    = ActCntDefault
) (
  input  logic                   clk_4f,
  input  logic                   reset,
  input  logic [LANES*SYM_W-1:0] lane_data_in,
  input  logic [LANES-1:0]       lane_valid_in,
  output logic [WORD_W-1:0]      data_out,
  output logic                   valid_out,
  output logic [LANES-1:0]       active,
  output logic                   skew_err
);

  localparam int unsigned BPW  = calc_bpw(WORD_W, SYM_W);
  localparam int unsigned IdxW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned ActW = $clog2(ACT_CNT + 1);
  localparam int unsigned RrW  = (LANES > 1) ? $clog2(LANES) : 1;

  logic [WORD_W-1:0] w_fifo_rdata [LANES];
  logic [LANES-1:0]  w_empty;
  logic [LANES-1:0]  w_full;
  logic [LANES-1:0]  w_overflow;
  logic [LANES-1:0]  w_pop;

  logic [RrW-1:0]    r_rr;
  logic [RrW-1:0]    w_rr_next;
  logic              w_rr_ready;
  logic [WORD_W-1:0] r_data_out;
  logic              r_valid_out;
  logic              r_skew_err;

  // Full flags are informational only; overflow is reported by the FIFO directly.
  logic w_unused_full;
  assign w_unused_full = ^w_full;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [SYM_W-1:0]  w_sym;
    logic              w_is_com;
    logic              w_accept;
    logic              w_last;
    logic [ActW-1:0]   r_act_cnt;
    logic [ActW-1:0]   w_act_cnt_d;
    logic              r_active;
    logic [IdxW-1:0]   r_idx;
    logic [WORD_W-1:0] r_word;
    logic [WORD_W-1:0] w_word_d;
    logic              r_push;

    assign w_sym    = lane_data_in[gi*SYM_W +: SYM_W];
    assign w_is_com = ~lane_valid_in[gi] & (w_sym == COM);
    // Uses the registered flag, so the cycle that raises active accepts nothing.
    assign w_accept = r_active & lane_valid_in[gi];
    assign w_last   = (r_idx == IdxW'(BPW - 1));

    // Saturating run-length count of idle COM symbols; any other symbol restarts it.
    always_comb begin
      w_act_cnt_d = '0;
      if (w_is_com) begin
        w_act_cnt_d = (r_act_cnt == ActW'(ACT_CNT)) ? r_act_cnt : r_act_cnt + 1'b1;
      end
    end

    // First accepted symbol of a word lands in the MSBs.
    always_comb begin
      w_word_d = r_word;
      for (int b = 0; b < BPW; b++) begin
        if (r_idx == IdxW'(b)) w_word_d[(BPW-1-b)*SYM_W +: SYM_W] = w_sym;
      end
    end

    always_ff @(posedge clk_4f) begin
      if (reset) begin
        r_act_cnt <= '0;
        r_active  <= 1'b0;
        r_idx     <= '0;
        r_word    <= '0;
        r_push    <= 1'b0;
      end else begin
        r_act_cnt <= w_act_cnt_d;
        r_active  <= r_active | (w_act_cnt_d == ActW'(ACT_CNT));
        r_push    <= w_accept & w_last;
        if (w_accept) begin
          r_word <= w_word_d;
          r_idx  <= w_last ? '0 : r_idx + 1'b1;
        end
      end
    end

    assign active[gi] = r_active;

    // r_word still holds the completed word during the push cycle: the next symbol
    // of the lane can only overwrite it on the same edge that the FIFO samples it.
    phy_lane_word_fifo #(
      .WORD_W (WORD_W),
      .DEPTH  (SKEW_DEPTH)
    ) u_fifo (
      .i_clk      (clk_4f),
      .i_reset    (reset),
      .i_push     (r_push),
      .i_wdata    (r_word),
      .i_pop      (w_pop[gi]),
      .o_rdata    (w_fifo_rdata[gi]),
      .o_full     (w_full[gi]),
      .o_empty    (w_empty[gi]),
      .o_overflow (w_overflow[gi])
    );
  end

  // Round-robin unstripe: wait on the selected lane, never skip it. Waiting here is
  // what realigns lanes that arrive late.
  always_comb begin
    w_pop      = '0;
    w_rr_ready = ~w_empty[r_rr];
    w_pop[r_rr] = w_rr_ready;
    w_rr_next  = (r_rr == RrW'(LANES - 1)) ? '0 : r_rr + 1'b1;
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      r_rr        <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_skew_err  <= 1'b0;
    end else begin
      r_valid_out <= w_rr_ready;
      if (w_rr_ready) begin
        r_data_out <= w_fifo_rdata[r_rr];
        r_rr       <= w_rr_next;
      end
      if (|w_overflow) r_skew_err <= 1'b1;
    end
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign skew_err  = r_skew_err;

endmodule

// File: tb/tb_phy_rx_lane_deskew.sv
// Directed bench for phy_rx_lane_deskew: DUT A uses default parameters, DUT B uses a
// two-word skew FIFO for the overflow scenario.
module tb_phy_rx_lane_deskew;

  localparam logic [7:0] COM = 8'hBC;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [15:0] ld_a, ld_b;
  logic [1:0]  lv_a, lv_b;
  logic [31:0] dout_a, dout_b;
  logic        valid_a, valid_b;
  logic [1:0]  act_a, act_b;
  logic        skew_a, skew_b;

  int checks = 0;
  int failures = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];

  phy_rx_lane_deskew u_dut_a (
    .clk_4f        (clk),
    .reset         (rst_a),
    .lane_data_in  (ld_a),
    .lane_valid_in (lv_a),
    .data_out      (dout_a),
    .valid_out     (valid_a),
    .active        (act_a),
    .skew_err      (skew_a)
  );

  phy_rx_lane_deskew #(
    .SKEW_DEPTH (2)
  ) u_dut_b (
    .clk_4f        (clk),
    .reset         (rst_b),
    .lane_data_in  (ld_b),
    .lane_valid_in (lv_b),
    .data_out      (dout_b),
    .valid_out     (valid_b),
    .active        (act_b),
    .skew_err      (skew_b)
  );

  // Output word collectors, sampled mid-cycle.
  always @(negedge clk) begin
    if (valid_a === 1'b1) qa.push_back(dout_a);
    if (valid_b === 1'b1) qb.push_back(dout_b);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [7:0] s0, input logic v0, input logic [7:0] s1,
                         input logic v1);
    ld_a = {s1, s0};
    lv_a = {v1, v0};
    step();
  endtask

  task automatic drive_b(input logic [7:0] s0, input logic v0, input logic [7:0] s1,
                         input logic v1);
    ld_b = {s1, s0};
    lv_b = {v1, v0};
    step();
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    ld_a = '0;
    lv_a = '0;
    step();
    step();
    rst_a = 1'b0;
    qa.delete();
  endtask

  task automatic reset_b();
    rst_b = 1'b1;
    ld_b = '0;
    lv_b = '0;
    step();
    step();
    rst_b = 1'b0;
    qb.delete();
  endtask

  task automatic activate_a();
    repeat (4) drive_a(COM, 1'b0, COM, 1'b0);
  endtask

  task automatic activate_b();
    repeat (4) drive_b(COM, 1'b0, COM, 1'b0);
  endtask

  task automatic test_reset();
    reset_a();
    checks++;
    if (dout_a !== 32'h0) begin
      failures++; $display("FAIL reset_data_out: got %h expected %h", dout_a, 32'h0);
    end
    checks++;
    if (valid_a !== 1'b0) begin
      failures++; $display("FAIL reset_valid_out: got %b expected 0", valid_a);
    end
    checks++;
    if (act_a !== 2'b00) begin
      failures++; $display("FAIL reset_active: got %b expected 00", act_a);
    end
    checks++;
    if (skew_a !== 1'b0) begin
      failures++; $display("FAIL reset_skew_err: got %b expected 0", skew_a);
    end
  endtask

  task automatic test_activation();
    reset_a();
    repeat (3) drive_a(COM, 1'b0, 8'h00, 1'b0);
    checks++;
    if (act_a !== 2'b00) begin
      failures++; $display("FAIL act_after_3com: got %b expected 00", act_a);
    end
    drive_a(8'h55, 1'b1, 8'h00, 1'b0);
    checks++;
    if (act_a !== 2'b00) begin
      failures++; $display("FAIL act_after_data: got %b expected 00", act_a);
    end
    repeat (3) drive_a(COM, 1'b0, 8'h00, 1'b0);
    checks++;
    if (act_a !== 2'b00) begin
      failures++; $display("FAIL act_3com_again: got %b expected 00", act_a);
    end
    drive_a(COM, 1'b0, 8'h00, 1'b0);
    checks++;
    if (act_a !== 2'b01) begin
      failures++; $display("FAIL act_after_4com: got %b expected 01", act_a);
    end
  endtask

  task automatic test_aligned();
    logic [31:0] exp_w [4];
    exp_w = '{32'h01020304, 32'h11121314, 32'h05060708, 32'h15161718};
    reset_a();
    activate_a();
    qa.delete();
    for (int i = 0; i < 8; i++) begin
      drive_a(8'(8'h01 + i), 1'b1, 8'(8'h11 + i), 1'b1);
      if (i == 3 || i == 4) begin
        checks++;
        if (valid_a !== 1'b0) begin
          failures++; $display("FAIL aligned_early_valid%0d: got %b expected 0", i, valid_a);
        end
      end
      if (i == 5) begin
        checks++;
        if (valid_a !== 1'b1 || dout_a !== 32'h01020304) begin
          failures++;
          $display("FAIL aligned_latency: got valid=%b data=%h expected valid=1 data=%h",
                   valid_a, dout_a, 32'h01020304);
        end
      end
    end
    repeat (6) drive_a(8'h00, 1'b0, 8'h00, 1'b0);
    checks++;
    if (qa.size() != 4) begin
      failures++; $display("FAIL aligned_count: got %0d expected 4", qa.size());
    end
    for (int k = 0; k < 4; k++) begin
      if (k < qa.size()) begin
        checks++;
        if (qa[k] !== exp_w[k]) begin
          failures++; $display("FAIL aligned_word%0d: got %h expected %h", k, qa[k], exp_w[k]);
        end
      end
    end
  endtask

  task automatic test_skew();
    logic [31:0] exp_w [4];
    exp_w = '{32'h01020304, 32'h11121314, 32'h05060708, 32'h15161718};
    reset_a();
    activate_a();
    qa.delete();
    for (int c = 0; c < 22; c++) begin
      drive_a((c < 8) ? 8'(8'h01 + c) : 8'h00, (c < 8),
              (c >= 6 && c < 14) ? 8'(8'h11 + c - 6) : 8'h00, (c >= 6 && c < 14));
    end
    checks++;
    if (qa.size() != 4) begin
      failures++; $display("FAIL skew_count: got %0d expected 4", qa.size());
    end
    for (int k = 0; k < 4; k++) begin
      if (k < qa.size()) begin
        checks++;
        if (qa[k] !== exp_w[k]) begin
          failures++; $display("FAIL skew_word%0d: got %h expected %h", k, qa[k], exp_w[k]);
        end
      end
    end
    checks++;
    if (skew_a !== 1'b0) begin
      failures++; $display("FAIL skew_no_err: got %b expected 0", skew_a);
    end
  endtask

  // Lane 0 word 0 drains at once (rr starts on lane 0); words 1 and 2 fill the
  // two-entry FIFO while rr waits on silent lane 1, so word 3 is the one dropped.
  task automatic test_overflow();
    logic [31:0] exp_w [5];
    exp_w = '{32'h20212223, 32'h40414243, 32'h24252627, 32'h44454647, 32'h28292A2B};
    reset_b();
    activate_b();
    qb.delete();
    for (int i = 0; i < 16; i++) drive_b(8'(8'h20 + i), 1'b1, 8'h00, 1'b0);
    checks++;
    if (skew_b !== 1'b0) begin
      failures++; $display("FAIL ovf_before_drop: got %b expected 0", skew_b);
    end
    drive_b(8'h00, 1'b0, 8'h00, 1'b0);
    checks++;
    if (skew_b !== 1'b1) begin
      failures++; $display("FAIL ovf_after_drop: got %b expected 1", skew_b);
    end
    for (int i = 0; i < 8; i++) drive_b(8'h00, 1'b0, 8'(8'h40 + i), 1'b1);
    repeat (8) drive_b(8'h00, 1'b0, 8'h00, 1'b0);
    checks++;
    if (qb.size() != 5) begin
      failures++; $display("FAIL ovf_count: got %0d expected 5", qb.size());
    end
    for (int k = 0; k < 5; k++) begin
      if (k < qb.size()) begin
        checks++;
        if (qb[k] !== exp_w[k]) begin
          failures++; $display("FAIL ovf_word%0d: got %h expected %h", k, qb[k], exp_w[k]);
        end
      end
    end
    checks++;
    if (skew_b !== 1'b1) begin
      failures++; $display("FAIL ovf_sticky: got %b expected 1", skew_b);
    end
  endtask

  task automatic test_valid_gaps();
    reset_a();
    activate_a();
    qa.delete();
    drive_a(8'hAA, 1'b1, 8'h00, 1'b0);
    repeat (3) drive_a(8'h00, 1'b0, 8'h00, 1'b0);
    drive_a(8'hBB, 1'b1, 8'h00, 1'b0);
    drive_a(8'hCC, 1'b1, 8'h00, 1'b0);
    drive_a(8'hDD, 1'b1, 8'h00, 1'b0);
    repeat (6) drive_a(8'h00, 1'b0, 8'h00, 1'b0);
    checks++;
    if (qa.size() != 1 || (qa.size() == 1 && qa[0] !== 32'hAABBCCDD)) begin
      failures++;
      $display("FAIL gaps_word: got count=%0d first=%h expected count=1 word=%h",
               qa.size(), (qa.size() > 0) ? qa[0] : 32'h0, 32'hAABBCCDD);
    end
    checks++;
    if (valid_a !== 1'b0 || dout_a !== 32'hAABBCCDD) begin
      failures++;
      $display("FAIL gaps_hold: got valid=%b data=%h expected valid=0 data=%h",
               valid_a, dout_a, 32'hAABBCCDD);
    end
  endtask

  task automatic test_mid_reset();
    reset_a();
    activate_a();
    for (int i = 0; i < 4; i++) drive_a(8'(8'h50 + i), 1'b1, 8'h00, 1'b0);
    repeat (4) drive_a(8'h00, 1'b0, 8'h00, 1'b0);
    checks++;
    if (dout_a !== 32'h50515253) begin
      failures++; $display("FAIL mrst_pre_word: got %h expected %h", dout_a, 32'h50515253);
    end
    drive_a(8'h61, 1'b1, 8'h00, 1'b0);
    drive_a(8'h62, 1'b1, 8'h00, 1'b0);
    rst_a = 1'b1;
    ld_a = '0;
    lv_a = '0;
    step();
    checks++;
    if (dout_a !== 32'h0 || valid_a !== 1'b0 || act_a !== 2'b00 || skew_a !== 1'b0) begin
      failures++;
      $display("FAIL mrst_outputs: got data=%h valid=%b active=%b skew=%b expected all 0",
               dout_a, valid_a, act_a, skew_a);
    end
    rst_a = 1'b0;
    qa.delete();
    for (int i = 0; i < 4; i++) drive_a(8'(8'h71 + i), 1'b1, 8'h00, 1'b0);
    repeat (3) drive_a(COM, 1'b0, 8'h00, 1'b0);
    checks++;
    if (act_a !== 2'b00) begin
      failures++; $display("FAIL mrst_3com: got %b expected 00", act_a);
    end
    drive_a(COM, 1'b0, 8'h00, 1'b0);
    checks++;
    if (act_a !== 2'b01) begin
      failures++; $display("FAIL mrst_4com: got %b expected 01", act_a);
    end
    for (int i = 0; i < 4; i++) drive_a(8'(8'h81 + i), 1'b1, 8'h00, 1'b0);
    repeat (6) drive_a(8'h00, 1'b0, 8'h00, 1'b0);
    checks++;
    if (qa.size() != 1 || (qa.size() == 1 && qa[0] !== 32'h81828384)) begin
      failures++;
      $display("FAIL mrst_word: got count=%0d first=%h expected count=1 word=%h",
               qa.size(), (qa.size() > 0) ? qa[0] : 32'h0, 32'h81828384);
    end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    ld_a = '0;
    lv_a = '0;
    ld_b = '0;
    lv_b = '0;
    test_reset();
    test_activation();
    test_aligned();
    test_skew();
    test_overflow();
    test_valid_gaps();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
